// File: rtl/rr_arb_2x1.sv
// rtl/rr_arb_2x1.sv - two-channel round-robin arbiter driving a downstream mux_2x1 select
// Optional multi-beat grant locking: RR_ARB_LOCK_EN
module rr_arb_2x1 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_last,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             sel,
   output logic [1:0]       grant
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT0 = 2'd1,
      S_GNT1 = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_prio;
   logic       r_sel;
   logic [1:0] r_grant;

   logic       w_hs0;
   logic       w_hs1;
   logic       w_end0;
   logic       w_end1;
   logic       w_out_valid;

   assign w_hs0 = (r_state == S_GNT0) && in0_valid && out_ready;
   assign w_hs1 = (r_state == S_GNT1) && in1_valid && out_ready;

`ifdef RR_ARB_LOCK_EN
   assign w_end0 = w_hs0 && in0_last;
   assign w_end1 = w_hs1 && in1_last;
`else
   logic w_unused_last;
   assign w_unused_last = in0_last ^ in1_last;
   assign w_end0        = w_hs0;
   assign w_end1        = w_hs1;
`endif

   // sel/grant are registered alongside the state so they never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_sel   <= 1'b0;
         r_grant <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in0_valid && (!in1_valid || !r_prio)) begin
                  r_state <= S_GNT0;
                  r_sel   <= 1'b1;
                  r_grant <= 2'b01;
               end else if (in1_valid) begin
                  r_state <= S_GNT1;
                  r_sel   <= 1'b0;
                  r_grant <= 2'b10;
               end
            end
            S_GNT0: begin
               if (w_end0) begin
                  r_prio <= 1'b1;
                  if (in1_valid) begin
                     r_state <= S_GNT1;
                     r_sel   <= 1'b0;
                     r_grant <= 2'b10;
                  end else begin
                     r_state <= S_IDLE;
                     r_sel   <= 1'b0;
                     r_grant <= 2'b00;
                  end
               end
            end
            S_GNT1: begin
               if (w_end1) begin
                  r_prio <= 1'b0;
                  if (in0_valid) begin
                     r_state <= S_GNT0;
                     r_sel   <= 1'b1;
                     r_grant <= 2'b01;
                  end else begin
                     r_state <= S_IDLE;
                     r_sel   <= 1'b0;
                     r_grant <= 2'b00;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sel   <= 1'b0;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Data path is purely combinational off the registered state
   always_comb begin
      w_out_valid = 1'b0;
      out_data    = '0;
      in0_ready   = 1'b0;
      in1_ready   = 1'b0;
      case (r_state)
         S_GNT0: begin
            w_out_valid = in0_valid;
            out_data    = in0_data;
            in0_ready   = out_ready;
         end
         S_GNT1: begin
            w_out_valid = in1_valid;
            out_data    = in1_data;
            in1_ready   = out_ready;
         end
         default: begin
            w_out_valid = 1'b0;
         end
      endcase
   end

`ifdef RR_ARB_LOCK_EN
   assign out_last = (r_state == S_GNT0) ? in0_last :
                     (r_state == S_GNT1) ? in1_last : 1'b0;
`else
   assign out_last = w_out_valid;
`endif

   assign out_valid = w_out_valid;
   assign sel       = r_sel;
   assign grant     = r_grant;

endmodule

// File: tb/tb_rr_arb_2x1.sv
// tb/tb_rr_arb_2x1.sv - directed self-checking bench for rr_arb_2x1
// Lock-mode steps are built only when RR_ARB_LOCK_EN is defined
module tb_rr_arb_2x1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in0_valid, in0_last, in0_ready;
   logic       in1_valid, in1_last, in1_ready;
   logic [7:0] in0_data, in1_data, out_data;
   logic       out_valid, out_last, out_ready, sel;
   logic [1:0] grant;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rr_arb_2x1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel),
      .grant     (grant)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_gnt, input logic e_sel,
                          input logic e_ov, input logic [7:0] e_od, input logic e_ol,
                          input logic e_r0, input logic e_r1);
      #1;
      chk({tag, "_grant"}, {14'd0, grant}, {14'd0, e_gnt});
      chk({tag, "_sel"}, {15'd0, sel}, {15'd0, e_sel});
      chk({tag, "_out_valid"}, {15'd0, out_valid}, {15'd0, e_ov});
      chk({tag, "_out_data"}, {8'd0, out_data}, {8'd0, e_od});
      chk({tag, "_out_last"}, {15'd0, out_last}, {15'd0, e_ol});
      chk({tag, "_in0_ready"}, {15'd0, in0_ready}, {15'd0, e_r0});
      chk({tag, "_in1_ready"}, {15'd0, in1_ready}, {15'd0, e_r1});
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 8'hA5;
      in1_data  = 8'h5A;
      in0_last  = 1'b1;
      in1_last  = 1'b1;
      out_ready = 1'b1;

      #2;
      chk_all("reset", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      tick;
      tick;
      rst_n = 1'b1;
      #1 chk("release_idle_grant", {14'd0, grant}, 16'h0000);
      tick;
      chk_all("first_gnt0", 2'b01, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);

      // Both channels busy: grant must alternate every beat with no bubble
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i % 2 == 0)
            chk_all("alt_gnt1", 2'b10, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
         else
            chk_all("alt_gnt0", 2'b01, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      end

      in1_valid = 1'b0;
      tick;
      chk_all("to_idle", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      in0_valid = 1'b0;
      in1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         #1;
         chk("single_grant", {14'd0, grant}, (i % 2 == 0) ? 16'h0002 : 16'h0000);
         chk("single_sel", {15'd0, sel}, 16'h0000);
      end

      // Granted channel drops valid: grant is held, other channel waits
      in1_valid = 1'b0;
      in0_valid = 1'b1;
      #1;
      chk("hold_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("hold_in0_ready", {15'd0, in0_ready}, 16'h0000);
      chk("hold_in1_ready", {15'd0, in1_ready}, 16'h0001);
      tick;
      #1 chk("hold_grant", {14'd0, grant}, 16'h0002);

      in1_valid = 1'b1;
      tick;
      #1 chk("switch_gnt0", {14'd0, grant}, 16'h0001);

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_all("bp", 2'b01, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
         tick;
      end
      out_ready = 1'b1;
      #1 chk("bp_release_in0_ready", {15'd0, in0_ready}, 16'h0001);
      tick;
      chk_all("bp_switch", 2'b10, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);

      // Async reset in GNT1 drops readies without waiting for a clock
      rst_n = 1'b0;
      chk_all("mid_reset", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick;
      rst_n = 1'b1;
      #1 chk("post_reset_idle", {14'd0, grant}, 16'h0000);
      tick;
      chk_all("post_reset_gnt0", 2'b01, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);

`ifdef RR_ARB_LOCK_EN
      in0_last = 1'b0;
      #1 chk("lock_out_last0", {15'd0, out_last}, 16'h0000);
      tick;
      #1 chk("lock_beat1_grant", {14'd0, grant}, 16'h0001);
      tick;
      #1 chk("lock_beat2_grant", {14'd0, grant}, 16'h0001);
      in0_last = 1'b1;
      #1 chk("lock_out_last1", {15'd0, out_last}, 16'h0001);
      tick;
      #1 chk("lock_release_grant", {14'd0, grant}, 16'h0002);
      chk("lock_prio", {15'd0, dut.r_prio}, 16'h0001);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rr_arb_2x1.md
# rr_arb_2x1

Two-channel round-robin arbiter that generates the select for, and forwards traffic through, a `mux_2x1` data-path stage. It sits directly upstream of the mux:
- It accepts two valid/ready request streams.
- It picks one stream fairly.
- It drives the `sel` line so that the downstream `mux_2x1` (sel=1 passes in0) steers the granted channel.
- It presents the selected beat on a single valid/ready output.

Grants are held for a whole transaction. Priority then rotates so neither channel can starve the other.

## Interface
- `WIDTH`, 8, data width of each channel.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in0_valid`  input  1  channel 0 beat valid.
- `in0_data`  input  WIDTH  channel 0 data.
- `in0_last`  input  1  channel 0 last beat of transaction (used only with `RR_ARB_LOCK_EN`).
- `in0_ready`  output  1  channel 0 beat accepted.
- `in1_valid`, `in1_data`, `in1_last`, `in1_ready`: same as channel 0, for channel 1.
- `out_valid`  output  1  selected beat valid.
- `out_data`  output  WIDTH  selected data.
- `out_last`  output  1  selected last flag.
- `out_ready`  input  1  downstream accepts beat.
- `sel`  output  1  mux select: 1 = channel 0 granted, 0 = otherwise.
- `grant`  output  2  one-hot grant; bit0 = ch0, bit1 = ch1; 2'b00 when idle.

## Operation
- States:
  - IDLE: no grant; `out_valid`=0; `out_data`=0; both readies 0.
  - GNT0: channel 0 granted.
  - GNT1: channel 1 granted.
- Priority pointer `prio` is 1 bit; 0 means ch0 wins ties.
- IDLE transitions:
  - Only in0_valid → GNT0.
  - Only in1_valid → GNT1.
  - Both valid → GNTprio.
  - Neither valid → stay in IDLE.
- GNTx:
  - `out_valid`=inx_valid, `out_data`=inx_data and `out_last`=inx_last, all combinational.
  - inx_ready=out_ready; the other channel's ready is 0.
- Handshake is inx_valid & out_ready.
- Transaction end:
  - Without the macro: every handshake.
  - With the macro: a handshake with inx_last=1.
- On transaction end from GNTx:
  - `prio` moves to the other channel.
  - Other channel valid this cycle → GNTother, with no bubble.
  - Otherwise → IDLE.
- Grant is never revoked mid-transaction.
  - A granted channel that drops valid keeps its grant.
  - The other channel waits.
- `sel` and `grant` are registered and decoded from state: `sel`=1 only in GNT0.
- `out_data` forced to 0 in IDLE; data is never registered (no width arithmetic).

## Timing
- Reset (async assert, sync deassert by the user):
  - state=IDLE, prio=0.
  - `sel`=0, `grant`=2'b00.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `in0_ready`=0, `in1_ready`=0.
- Latency from IDLE: a request seen at edge N gives a grant from edge N+1 onward, so `out_valid` rises 1 cycle after the request.
- Back-to-back between channels: full throughput, with a switch on the cycle after transaction end.
- Same channel continuing with the other channel idle: one IDLE bubble cycle between transactions.
- Simultaneous request while idle: resolved by `prio`; `prio` changes only at transaction end.
- Reset mid-transaction:
  - Returns to IDLE and drops readies immediately, asynchronously.
  - The in-flight beat is lost; upstream must re-present it.
- out_ready=0 while granted: the grant is held, inx_ready=0, and `out_*` mirror the channel unchanged.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - Grant is locked across multi-beat transactions.
  - Release and `prio` rotation occur only on a handshake with last=1.
  - `out_last` = granted inx_last.
- `RR_ARB_LOCK_EN` undefined:
  - Every accepted beat is a transaction and rotates priority.
  - `inx_last` inputs are ignored; `out_last` is tied 1 while `out_valid`=1, 0 otherwise.

## Test plan
- Reset checks:
  - Assert rst_n=0 with both valids high → all outputs 0 and grant=2'b00 immediately.
  - Release rst_n, then hold both valids high → the next cycle gives grant=01 and sel=1.
- Alternation: both channels valid continuously, out_ready=1, in0_data=8'hA5, in1_data=8'h5A, macro off → out_data alternates A5,5A,A5… with no idle cycle; in0_ready and in1_ready alternate.
- Single channel: in1_valid only, 3 beats, out_ready=1 → grant 10,00,10,00,10 (bubble between beats); sel stays 0.
- Backpressure: GNT0 with out_ready=0 for 4 cycles while in1_valid=1 → grant stays 01, in1_ready=0, and out_data is stable; on out_ready=1 the switch to GNT1 occurs next cycle.
- Lock (macro on): ch0 sends 3 beats (last on the third) while ch1 is valid throughout → ch1 is granted only on the cycle after ch0's third handshake; prio=1 afterward.
- Mid-transaction reset: reset in GNT1 with in1_valid=1 → readies drop in the same cycle; after release, prio=0 and an idle-to-grant latency of 1 cycle is seen.
